aes_key_expand_128: RTL and testbench
=====================================

// Module: aes_key_expand_128
// PURPOSE
//  Iterative AES-128 key schedule. Streams round keys 0..10 on a valid/ready handshake, one per cycle at full rate.
//  Sits upstream of the round datapath (AddRoundKey) and consumes four S-box LUT lookups per round for SubWord.
// PARAMETERS
//  NR      10  number of rounds; only 10 supported, fixes the last index
//  IDX_W   4   width of rk_idx / rd_idx
// PORTS
//  clk       in   1    single clock; all state changes on posedge
//  rst       in   1    synchronous, active-high reset
//  start     in   1    begin expansion of key; accepted only when busy=0
//  key       in   128  cipher key; sampled on the accepted start
//  busy      out  1    expansion in progress
//  rk_valid  out  1    rk / rk_idx hold a valid round key
//  rk_ready  in   1    downstream accepts the current round key
//  rk        out  128  round key, word0 in [127:96]
//  rk_idx    out  IDX_W round index 0..10
//  done      out  1    1-cycle pulse after round key 10 is accepted
//  rd_idx    in   IDX_W stored-key read index (AES_KEY_STORE_EN only)
//  rd_key    out  128  stored round key, combinational read (AES_KEY_STORE_EN only)
//  keys_ok   out  1    all 11 keys stored (AES_KEY_STORE_EN only)
// BEHAVIOUR
//  Reset: state=IDLE; busy, rk_valid, done, keys_ok = 0; rk, rk_idx = 0.
//  FSM IDLE->RUN on start&!busy; RUN->IDLE on (rk_valid&rk_ready&rk_idx==NR).
//  Start accepted at cycle t: at t+1 busy=1, rk_valid=1, rk=key, rk_idx=0.
//  Start while busy=1 is ignored; key is not resampled.
//  Handshake = rk_valid&rk_ready.
//   - On a handshake with rk_idx<NR, the next cycle has rk=next(rk,rcon[rk_idx+1]) and rk_idx+1.
//   - With rk_ready=1 held, the 11 keys occupy 11 consecutive cycles.
//  Stall: while rk_valid&!rk_ready, rk and rk_idx hold stable; no key is skipped or recomputed.
//  next(): t = SubWord(RotWord(w3)) ^ {rcon,24'h0}; w0'=w0^t; w1'=w1^w0'; w2'=w2^w1'; w3'=w3^w2'.
//  rcon[1..10] = 01,02,04,08,10,20,40,80,1b,36; GF(2^8) bytes only, no carries.
//  Completion: the handshake at rk_idx==NR completes expansion. The next cycle has rk_valid=0, busy=0, done=1 for one cycle.
//   - start is legal in that same done cycle.
//   - rk keeps its last value; rk_idx returns to 0.
//  rst mid-expansion: abort immediately to the reset values; no done pulse.
//  rk_ready while rk_valid=0 has no effect.
// CONFIGURATION
//  AES_KEY_STORE_EN defined:
//   - Instantiates an 11x128 register array; entry rk_idx is written on each handshake.
//   - rd_key = array[rd_idx]; rd_idx>10 returns 0.
//   - keys_ok is set with done and cleared on accepted start or rst.
//  AES_KEY_STORE_EN undefined:
//   - No array, no rd_idx/rd_key/keys_ok ports; streaming only.
// STRUCTURE
//  Shared package aes_pkg: AES_NR=10, RCON table (function aes_rcon(idx)), state encoding {IDLE,RUN}, 128-bit word helpers.
//  Sub-module aes_key_round: combinational next(rk,rcon) wrapping four aes_sbox_lut instances on RotWord(w3).
//  Top holds the FSM, rk/rk_idx registers, handshake logic and the optional store.
// TESTING
//  FIPS-197 vector: key=2b7e151628aed2a6abf7158809cf4f3c, rk_ready=1
//   -> rk0=key, rk1=a0fafe1788542cb123a339392a6c7605, rk10=d014f9a8c9ee2589e13f0cc8b6630ca6.
//   -> done one cycle after rk10; 12 cycles from start to done.
//  Zero key
//   -> rk1=62636363626363636263636362636363, rk10=b4ef5bcb3e92e21123e951cf6f8f188e.
//  Backpressure: FIPS key, rk_ready toggled randomly incl. 5-cycle stall at idx 9
//   -> the same 11 keys in order; rk stable during stalls.
//  Start while busy at idx 4 with key=0
//   -> ignored; the FIPS sequence completes unchanged.
//  rst asserted at idx 6
//   -> next cycle busy=rk_valid=done=0, rk_idx=0.
//   -> new start with zero key yields a correct zero-key sequence.
//  AES_KEY_STORE_EN: after FIPS run
//   -> keys_ok=1; rd_idx=1 gives a0fafe17...7605; rd_idx=15 gives 0.
//   -> new start clears keys_ok.

Source files
------------

// File: rtl/aes_pkg.sv
// Shared AES definitions: round count, index width, FSM encoding, RCON and word helpers.
package aes_pkg;

  localparam int unsigned AES_NR    = 10;
  localparam int unsigned AES_IDX_W = 4;
  localparam int unsigned AES_KEY_W = 128;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  // Round constant for round idx (1..10); other indices yield 0.
  function automatic logic [7:0] aes_rcon(input logic [AES_IDX_W-1:0] idx);
    logic [7:0] r;
    case (idx)
      4'd1:    r = 8'h01;
      4'd2:    r = 8'h02;
      4'd3:    r = 8'h04;
      4'd4:    r = 8'h08;
      4'd5:    r = 8'h10;
      4'd6:    r = 8'h20;
      4'd7:    r = 8'h40;
      4'd8:    r = 8'h80;
      4'd9:    r = 8'h1b;
      4'd10:   r = 8'h36;
      default: r = 8'h00;
    endcase
    return r;
  endfunction

  // Word i of a 128-bit block; word 0 occupies the top bits.
  function automatic logic [31:0] aes_get_word(input logic [AES_KEY_W-1:0] b,
                                               input logic [1:0] i);
    return b[32*(3-int'(i)) +: 32];
  endfunction

  // Cyclic left rotation of a word by one byte.
  function automatic logic [31:0] aes_rot_word(input logic [31:0] w);
    return {w[23:0], w[31:24]};
  endfunction

endpackage

// File: rtl/aes_key_round.sv
// One AES-128 key-schedule step: next round key from the current one and its rcon.
module aes_key_round
  import aes_pkg::*;
(
  input  logic [AES_KEY_W-1:0] cur,
  input  logic [7:0]           rcon,
  output logic [AES_KEY_W-1:0] nxt_c
);

  logic [31:0] rot;
  logic [31:0] sub;
  logic [31:0] t;
  logic [31:0] w0, w1, w2, w3;

  assign rot = aes_rot_word(aes_get_word(cur, 2'd3));

  // SubWord: one S-box per byte of the rotated last word.
  for (genvar i = 0; i < 4; i++) begin : g_sbox
    aes_sbox_lut u_sbox (
      .a   (rot[8*i +: 8]),
      .y_c (sub[8*i +: 8])
    );
  end

  // Chained XOR of the four words.
  always_comb begin
    t     = sub ^ {rcon, 24'h0};
    w0    = aes_get_word(cur, 2'd0) ^ t;
    w1    = aes_get_word(cur, 2'd1) ^ w0;
    w2    = aes_get_word(cur, 2'd2) ^ w1;
    w3    = aes_get_word(cur, 2'd3) ^ w2;
    nxt_c = {w0, w1, w2, w3};
  end

endmodule

// File: rtl/aes_sbox_lut.sv
// AES forward S-box as a 256-entry constant lookup table.
module aes_sbox_lut (
  input  logic [7:0] a,
  output logic [7:0] y_c
);

  localparam logic [7:0] SBOX [256] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  assign y_c = SBOX[a];

endmodule

// File: rtl/aes_key_expand_128.sv
// Iterative AES-128 key schedule streaming round keys 0..10 over valid/ready.
// Optional round-key store enabled by defining AES_KEY_STORE_EN.
module aes_key_expand_128
  import aes_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [AES_KEY_W-1:0] key,
  output logic                 busy,
  output logic                 rk_valid,
  input  logic                 rk_ready,
  output logic [AES_KEY_W-1:0] rk,
  output logic [AES_IDX_W-1:0] rk_idx,
  output logic                 done
`ifdef AES_KEY_STORE_EN
  ,
  input  logic [AES_IDX_W-1:0] rd_idx,
  output logic [AES_KEY_W-1:0] rd_key,
  output logic                 keys_ok
`endif
);

  state_t               state, state_d;
  logic                 busy_d, valid_d, done_d;
  logic [AES_KEY_W-1:0] rk_d, rk_nxt;
  logic [AES_IDX_W-1:0] idx_d;
  logic                 hs;
  logic                 start_acc;

  assign hs        = rk_valid & rk_ready;
  assign start_acc = (state == IDLE) & start & ~busy;

  aes_key_round u_round (
    .cur   (rk),
    .rcon  (aes_rcon(rk_idx + AES_IDX_W'(1))),
    .nxt_c (rk_nxt)
  );

  // State and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      busy     <= 1'b0;
      rk_valid <= 1'b0;
      done     <= 1'b0;
      rk       <= '0;
      rk_idx   <= '0;
    end else begin
      state    <= state_d;
      busy     <= busy_d;
      rk_valid <= valid_d;
      done     <= done_d;
      rk       <= rk_d;
      rk_idx   <= idx_d;
    end
  end

  // Next state: load key on start, advance on handshake, finish after key NR.
  always_comb begin
    state_d = state;
    busy_d  = busy;
    valid_d = rk_valid;
    done_d  = 1'b0;
    rk_d    = rk;
    idx_d   = rk_idx;
    case (state)
      IDLE: begin
        if (start_acc) begin
          state_d = RUN;
          busy_d  = 1'b1;
          valid_d = 1'b1;
          rk_d    = key;
          idx_d   = '0;
        end
      end
      RUN: begin
        if (hs) begin
          if (rk_idx == AES_IDX_W'(AES_NR)) begin
            state_d = IDLE;
            busy_d  = 1'b0;
            valid_d = 1'b0;
            done_d  = 1'b1;
            idx_d   = '0;
          end else begin
            rk_d  = rk_nxt;
            idx_d = rk_idx + AES_IDX_W'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

`ifdef AES_KEY_STORE_EN
  logic [AES_KEY_W-1:0] store_q [AES_NR+1];

  // Capture each round key as it is handed off.
  always_ff @(posedge clk) begin
    if (hs && !rst && (rk_idx <= AES_IDX_W'(AES_NR))) begin
      store_q[rk_idx] <= rk;
    end
  end

  // keys_ok: set with done, cleared by a new expansion.
  always_ff @(posedge clk) begin
    if (rst || start_acc) begin
      keys_ok <= 1'b0;
    end else if (done_d) begin
      keys_ok <= 1'b1;
    end
  end

  // Combinational read port; out-of-range indices read as zero.
  always_comb begin
    rd_key = '0;
    if (rd_idx <= AES_IDX_W'(AES_NR)) begin
      rd_key = store_q[rd_idx];
    end
  end
`endif

endmodule

// File: tb/tb_aes_key_expand_128.sv
// Self-checking bench for aes_key_expand_128: vector table, scoreboard, corner sequences.
// Define AES_KEY_STORE_EN to also exercise the round-key store.
module tb_aes_key_expand_128;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [127:0] key;
  logic         busy;
  logic         rk_valid;
  logic         rk_ready;
  logic [127:0] rk;
  logic [3:0]   rk_idx;
  logic         done;
`ifdef AES_KEY_STORE_EN
  logic [3:0]   rd_idx;
  logic [127:0] rd_key;
  logic         keys_ok;
`endif

  aes_key_expand_128 dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .key      (key),
    .busy     (busy),
    .rk_valid (rk_valid),
    .rk_ready (rk_ready),
    .rk       (rk),
    .rk_idx   (rk_idx),
    .done     (done)
`ifdef AES_KEY_STORE_EN
    ,
    .rd_idx   (rd_idx),
    .rd_key   (rd_key),
    .keys_ok  (keys_ok)
`endif
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct packed {
    logic [127:0] k;
    logic [3:0]   idx;
  } exp_t;
  exp_t sbq[$];

  typedef struct {
    logic [127:0] k;
    logic [127:0] rk1;
    logic [127:0] rk10;
  } vec_t;
  vec_t vecs [2];

  logic [127:0] got [11];
  localparam logic [127:0] FIPS_KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] FIPS_RK1 = 128'ha0fafe1788542cb123a339392a6c7605;
  localparam logic [127:0] FIPS_RK10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
  localparam logic [127:0] ZERO_RK1 = 128'h62636363626363636263636362636363;
  localparam logic [127:0] ZERO_RK10 = 128'hb4ef5bcb3e92e21123e951cf6f8f188e;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference model: S-box derived from the GF(2^8) inverse and affine map.
  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    logic [7:0] x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xtime(x);
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
    return (b << n) | (b >> (8 - n));
  endfunction

  function automatic logic [7:0] m_sbox(input logic [7:0] a);
    logic [7:0] inv = 8'h01;
    logic [7:0] b;
    for (int i = 0; i < 254; i++) inv = gmul(inv, a);
    b = (a == 8'h00) ? 8'h00 : inv;
    return b ^ rotl8(b, 1) ^ rotl8(b, 2) ^ rotl8(b, 3) ^ rotl8(b, 4) ^ 8'h63;
  endfunction

  function automatic logic [7:0] m_rcon(input int i);
    logic [7:0] r = 8'h01;
    for (int j = 1; j < i; j++) r = xtime(r);
    return r;
  endfunction

  function automatic logic [127:0] m_next(input logic [127:0] r, input logic [7:0] rc);
    logic [31:0] w3, rot, t, a, b, c, d;
    w3  = r[31:0];
    rot = {w3[23:0], w3[31:24]};
    t   = {m_sbox(rot[31:24]), m_sbox(rot[23:16]), m_sbox(rot[15:8]), m_sbox(rot[7:0])};
    t   = t ^ {rc, 24'h0};
    a   = r[127:96] ^ t;
    b   = r[95:64] ^ a;
    c   = r[63:32] ^ b;
    d   = r[31:0] ^ c;
    return {a, b, c, d};
  endfunction

  // Scoreboard consumer and stall-stability monitor, sampled mid-cycle.
  logic [127:0] held_rk;
  logic [3:0]   held_idx;
  logic         stalled = 1'b0;
  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      stalled = 1'b0;
    end else begin
      if (stalled && rk_valid) begin
        check("stall_rk", rk, held_rk);
        check("stall_idx", 128'(rk_idx), 128'(held_idx));
      end
      stalled  = rk_valid && !rk_ready;
      held_rk  = rk;
      held_idx = rk_idx;
      if (rk_valid && rk_ready) begin
        if (sbq.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL sb_unexpected: got key idx %0d, expected none", rk_idx);
        end else begin
          e = sbq.pop_front();
          check("sb_rk", rk, e.k);
          check("sb_idx", 128'(rk_idx), 128'(e.idx));
          if (rk_idx <= 4'd10) got[rk_idx] = rk;
        end
      end
    end
  end

  // mode 0: ready held; 1: random ready + long stall at idx 9;
  // 2: start (key 0) while busy at idx 4; 3: reset at idx 6.
  task automatic run(input logic [127:0] k, input int mode);
    logic [127:0] r;
    int cyc = 0;
    int stall = 0;
    bit injected = 1'b0;
    while (busy && cyc < 50) begin
      @(posedge clk); #1; cyc++;
    end
    check("idle_before_start", 128'(busy), 128'(0));
    start = 1'b1;
    key   = k;
    r = k;
    for (int i = 0; i <= 10; i++) begin
      sbq.push_back('{k: r, idx: 4'(i)});
      if (i < 10) r = m_next(r, m_rcon(i + 1));
    end
    rk_ready = (mode == 1) ? 1'($urandom_range(0, 1)) : 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    cyc = 1;
    check("accept_busy", 128'(busy), 128'(1));
    check("accept_valid", 128'(rk_valid), 128'(1));
    check("accept_idx", 128'(rk_idx), 128'(0));
    check("accept_rk0", rk, k);
`ifdef AES_KEY_STORE_EN
    check("start_clears_keys_ok", 128'(keys_ok), 128'(0));
`endif
    while (!done && cyc < 300) begin
      if (mode == 3 && rk_valid && rk_idx == 4'd6) begin
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("rst_busy", 128'(busy), 128'(0));
        check("rst_valid", 128'(rk_valid), 128'(0));
        check("rst_done", 128'(done), 128'(0));
        check("rst_idx", 128'(rk_idx), 128'(0));
        check("rst_rk", rk, 128'(0));
        sbq.delete();
        return;
      end
      start = 1'b0;
      if (mode == 2 && rk_valid && rk_idx == 4'd4 && !injected) begin
        start    = 1'b1;
        key      = '0;
        injected = 1'b1;
      end
      if (mode == 1) begin
        if (rk_valid && rk_idx == 4'd9 && stall < 5) begin
          rk_ready = 1'b0;
          stall++;
        end else begin
          rk_ready = 1'($urandom_range(0, 1));
        end
      end
      @(posedge clk); #1;
      cyc++;
    end
    start = 1'b0;
    if (!done) begin
      n_tests++;
      n_fail++;
      $display("FAIL done_timeout: no done after %0d cycles, expected one", cyc);
      return;
    end
    check("done_busy", 128'(busy), 128'(0));
    check("done_valid", 128'(rk_valid), 128'(0));
    check("done_idx", 128'(rk_idx), 128'(0));
    check("done_rk_hold", rk, r);
    check("sb_drained", 128'(sbq.size()), 128'(0));
    if (mode == 0 || mode == 2) check("start_to_done_cycles", 128'(cyc), 128'(12));
    if (mode == 1) check("stall_len_idx9", 128'(stall), 128'(5));
    @(posedge clk); #1;
    check("done_pulse_1cyc", 128'(done), 128'(0));
  endtask

  initial begin
    vecs[0] = '{k: FIPS_KEY, rk1: FIPS_RK1, rk10: FIPS_RK10};
    vecs[1] = '{k: 128'h0,   rk1: ZERO_RK1, rk10: ZERO_RK10};

    rst      = 1'b1;
    start    = 1'b0;
    key      = '0;
    rk_ready = 1'b0;
`ifdef AES_KEY_STORE_EN
    rd_idx   = '0;
`endif
    repeat (3) @(posedge clk);
    #1;
    check("reset_busy", 128'(busy), 128'(0));
    check("reset_valid", 128'(rk_valid), 128'(0));
    check("reset_done", 128'(done), 128'(0));
    check("reset_rk", rk, 128'(0));
    check("reset_idx", 128'(rk_idx), 128'(0));
`ifdef AES_KEY_STORE_EN
    check("reset_keys_ok", 128'(keys_ok), 128'(0));
`endif
    rst = 1'b0;
    @(posedge clk); #1;

    for (int v = 0; v < 2; v++) begin
      run(vecs[v].k, 0);
      check("vec_rk0", got[0], vecs[v].k);
      check("vec_rk1", got[1], vecs[v].rk1);
      check("vec_rk10", got[10], vecs[v].rk10);
`ifdef AES_KEY_STORE_EN
      if (v == 0) begin
        check("keys_ok_after_run", 128'(keys_ok), 128'(1));
        rd_idx = 4'd1;  #1;
        check("rd_key_1", rd_key, FIPS_RK1);
        rd_idx = 4'd10; #1;
        check("rd_key_10", rd_key, FIPS_RK10);
        rd_idx = 4'd15; #1;
        check("rd_key_15", rd_key, 128'(0));
      end
`endif
    end

    run(FIPS_KEY, 1);
    check("bp_rk10", got[10], FIPS_RK10);

    run(FIPS_KEY, 2);
    check("busy_start_rk1", got[1], FIPS_RK1);
    check("busy_start_rk10", got[10], FIPS_RK10);

    run(FIPS_KEY, 3);
    run(128'h0, 0);
    check("post_rst_rk1", got[1], ZERO_RK1);
    check("post_rst_rk10", got[10], ZERO_RK10);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
